// File: rtl/ub_pkg.sv
// Shared sizing defaults and read-sequencer state encoding for the unified-buffer controller.
package ub_pkg;

    localparam int unsigned UB_RAM_WIDTH = 128;
    localparam int unsigned UB_RAM_DEPTH = 256;
    localparam int unsigned UB_ADDR_W    = $clog2(UB_RAM_DEPTH);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ub_rd_fifo.sv
// Two-entry register FIFO holding BRAM read returns until the array accepts them.
module ub_rd_fifo
    import ub_pkg::*;
#(
    parameter int unsigned Width = UB_RAM_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i & (count_q != 2'd0);
    assign do_push = push_i & ((count_q != 2'd2) | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/ub_access_ctrl.sv
// Unified-buffer BRAM access controller: host/accumulator write arbitration plus a
// backpressured burst-read sequencer feeding the systolic array.
module ub_access_ctrl
    import ub_pkg::*;
#(
    parameter int unsigned  RAM_WIDTH = UB_RAM_WIDTH,
    parameter int unsigned  RAM_DEPTH = UB_RAM_DEPTH,
    localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_base,
    input  logic [ADDR_W:0]      cmd_len,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 rd_last,
    output logic                 busy,
    input  logic                 host_wr_valid,
    output logic                 host_wr_ready,
    input  logic [ADDR_W-1:0]    host_wr_addr,
    input  logic [RAM_WIDTH-1:0] host_wr_data,
    input  logic                 acc_wr_valid,
    output logic                 acc_wr_ready,
    input  logic [ADDR_W-1:0]    acc_wr_addr,
    input  logic [RAM_WIDTH-1:0] acc_wr_data,
    output logic                 bram_wea,
    output logic [ADDR_W-1:0]    bram_addra,
    output logic [RAM_WIDTH-1:0] bram_dina,
    output logic                 bram_enb,
    output logic [ADDR_W-1:0]    bram_addrb,
    input  logic [RAM_WIDTH-1:0] bram_doutb
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    rd_state_e            state_q;
    logic                 cmd_ready_q;
    logic                 busy_q;
    logic                 inflight_q;
    logic [ADDR_W-1:0]    base_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     iss_q;
    logic [LEN_W-1:0]     ret_q;
    logic                 rr_q;  // 1: accumulator wins the next tie

    logic                 host_gnt;
    logic                 acc_gnt;
    logic                 cmd_accept;
    logic                 pop;
    logic                 issue;
    logic                 last_issue;
    logic                 last_beat;
    logic [2:0]           occupancy;
    logic [1:0]           fifo_count;
    logic                 fifo_valid;
    logic [RAM_WIDTH-1:0] fifo_data;

    // Write arbiter
    assign host_wr_ready = ~acc_wr_valid | ~rr_q;
    assign acc_wr_ready  = ~host_wr_valid | rr_q;
    assign host_gnt      = host_wr_valid & host_wr_ready;
    assign acc_gnt       = acc_wr_valid & acc_wr_ready;
    assign bram_wea      = host_gnt | acc_gnt;
    assign bram_addra    = acc_gnt ? acc_wr_addr : host_wr_addr;
    assign bram_dina     = acc_gnt ? acc_wr_data : host_wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else if (host_wr_valid && acc_wr_valid) begin
            rr_q <= ~rr_q;
        end
    end

    // A word popped this cycle frees its slot, so it does not count against the next issue.
    assign pop        = fifo_valid & rd_ready;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == StStream) && (occupancy < 3'd2);
    assign last_issue = (iss_q + LEN_W'(1)) == len_q;
    assign last_beat  = (ret_q + LEN_W'(1)) == len_q;
    assign cmd_accept = cmd_valid & cmd_ready_q;

    assign bram_enb   = issue;
    assign bram_addrb = base_q + iss_q[ADDR_W-1:0];
    assign rd_valid   = fifo_valid;
    assign rd_data    = fifo_data;
    assign rd_last    = fifo_valid & last_beat;
    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            inflight_q  <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
            iss_q       <= '0;
            ret_q       <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                iss_q <= iss_q + LEN_W'(1);
            end
            if (pop) begin
                ret_q <= ret_q + LEN_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (cmd_accept) begin
                        base_q <= cmd_base;
                        len_q  <= cmd_len;
                        iss_q  <= '0;
                        ret_q  <= '0;
                        if (cmd_len != '0) begin
                            state_q     <= StStream;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                StStream: begin
                    if (issue && last_issue) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && last_beat) begin
                        state_q     <= StIdle;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    ub_rd_fifo #(
        .Width (RAM_WIDTH)
    ) u_rd_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (inflight_q),
        .data_i  (bram_doutb),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_ub_access_ctrl.sv
// Directed bench for ub_access_ctrl with a behavioural simple-dual-port BRAM model.
module tb_ub_access_ctrl;

    localparam int unsigned W  = 128;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic          busy;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    logic [W-1:0]  host_wr_data;
    logic          acc_wr_valid;
    logic          acc_wr_ready;
    logic [AW-1:0] acc_wr_addr;
    logic [W-1:0]  acc_wr_data;
    logic          bram_wea;
    logic [AW-1:0] bram_addra;
    logic [W-1:0]  bram_dina;
    logic          bram_enb;
    logic [AW-1:0] bram_addrb;
    logic [W-1:0]  bram_doutb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ub_access_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base      (cmd_base),
        .cmd_len       (cmd_len),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_last       (rd_last),
        .busy          (busy),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .acc_wr_valid  (acc_wr_valid),
        .acc_wr_ready  (acc_wr_ready),
        .acc_wr_addr   (acc_wr_addr),
        .acc_wr_data   (acc_wr_data),
        .bram_wea      (bram_wea),
        .bram_addra    (bram_addra),
        .bram_dina     (bram_dina),
        .bram_enb      (bram_enb),
        .bram_addrb    (bram_addrb),
        .bram_doutb    (bram_doutb)
    );

    // BRAM model: registered read returns the pre-write contents on a same-address collision.
    logic [W-1:0] mem [256];
    always @(posedge clk) begin
        if (bram_wea) mem[bram_addra] <= bram_dina;
        if (bram_enb) bram_doutb <= mem[bram_addrb];
    end

    function automatic logic [W-1:0] word_of(input logic [7:0] a);
        return {16{a}};
    endfunction

    // Stimulus tasks start and end 1 time unit after a rising edge.
    task automatic host_write(input logic [7:0] a, input logic [W-1:0] d);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        @(posedge clk); #1;
        host_wr_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic [7:0] base, input logic [8:0] len);
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        cmd_valid     = 1'b0;
        cmd_base      = '0;
        cmd_len       = '0;
        rd_ready      = 1'b0;
        host_wr_valid = 1'b0;
        host_wr_addr  = '0;
        host_wr_data  = '0;
        acc_wr_valid  = 1'b0;
        acc_wr_addr   = '0;
        acc_wr_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b expected 0", rd_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bram_enb !== 1'b0) begin errors++; $display("FAIL reset_bram_enb: got %b expected 0", bram_enb); end
        checks++; if (bram_wea !== 1'b0) begin errors++; $display("FAIL reset_bram_wea: got %b expected 0", bram_wea); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected ready=1 busy=0", cmd_ready, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int beats = 0;
        int prev  = -1;
        for (int i = 0; i < 16; i++) host_write(8'(i), word_of(8'(i)));
        rd_ready = 1'b1;
        issue_cmd(8'd0, 9'd16);
        for (int c = 0; c < 40 && beats < 16; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                checks++; if (rd_data !== word_of(8'(beats))) begin errors++; $display("FAIL stream_data beat %0d: got %h expected %h", beats, rd_data, word_of(8'(beats))); end
                checks++; if (rd_last !== (beats == 15)) begin errors++; $display("FAIL stream_last beat %0d: got %b expected %b", beats, rd_last, (beats == 15)); end
                if (beats == 0) begin
                    checks++; if (c != 2) begin errors++; $display("FAIL stream_first_latency: got %0d cycles expected 2", c); end
                end else begin
                    checks++; if (c != prev + 1) begin errors++; $display("FAIL stream_gap beat %0d: got cycle %0d expected %0d", beats, c, prev + 1); end
                end
                prev = c;
                beats++;
            end
            @(posedge clk); #1;
        end
        checks++; if (beats != 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", beats); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL stream_end_idle: got busy=%b ready=%b valid=%b expected 0 1 0", busy, cmd_ready, rd_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_arbiter();
        logic exp_host;
        host_wr_valid = 1'b1;
        host_wr_addr  = 8'h40;
        host_wr_data  = {16{8'h11}};
        acc_wr_valid  = 1'b1;
        acc_wr_addr   = 8'h50;
        acc_wr_data   = {16{8'h22}};
        for (int i = 0; i < 4; i++) begin
            exp_host = ((i % 2) == 0);
            @(negedge clk);
            checks++; if (bram_wea !== 1'b1) begin errors++; $display("FAIL arb_wea cycle %0d: got %b expected 1", i, bram_wea); end
            checks++; if (host_wr_ready !== exp_host || acc_wr_ready !== !exp_host) begin errors++; $display("FAIL arb_grant cycle %0d: got host=%b acc=%b expected host=%b acc=%b", i, host_wr_ready, acc_wr_ready, exp_host, !exp_host); end
            checks++; if (bram_addra !== (exp_host ? 8'h40 : 8'h50)) begin errors++; $display("FAIL arb_addr cycle %0d: got %h expected %h", i, bram_addra, (exp_host ? 8'h40 : 8'h50)); end
            checks++; if (bram_dina !== (exp_host ? {16{8'h11}} : {16{8'h22}})) begin errors++; $display("FAIL arb_data cycle %0d: got %h", i, bram_dina); end
            @(posedge clk); #1;
        end
        host_wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (acc_wr_ready !== 1'b1 || bram_wea !== 1'b1 || bram_addra !== 8'h50) begin errors++; $display("FAIL arb_acc_alone: got ready=%b wea=%b addr=%h expected 1 1 50", acc_wr_ready, bram_wea, bram_addra); end
        @(posedge clk); #1;
        acc_wr_valid = 1'b0;
    endtask

    task automatic test_wrap();
        int beats = 0;
        int iss   = 0;
        for (int i = 250; i < 256; i++) host_write(8'(i), word_of(8'(i)));
        rd_ready = 1'b1;
        issue_cmd(8'd250, 9'd10);
        for (int c = 0; c < 40 && beats < 10; c++) begin
            @(negedge clk);
            if (bram_enb) begin
                checks++; if (bram_addrb !== 8'(250 + iss)) begin errors++; $display("FAIL wrap_addr issue %0d: got %h expected %h", iss, bram_addrb, 8'(250 + iss)); end
                iss++;
            end
            if (rd_valid) begin
                checks++; if (rd_data !== word_of(8'(250 + beats))) begin errors++; $display("FAIL wrap_data beat %0d: got %h expected %h", beats, rd_data, word_of(8'(250 + beats))); end
                checks++; if (rd_last !== (beats == 9)) begin errors++; $display("FAIL wrap_last beat %0d: got %b expected %b", beats, rd_last, (beats == 9)); end
                beats++;
            end
            @(posedge clk); #1;
        end
        checks++; if (beats != 10 || iss != 10) begin errors++; $display("FAIL wrap_count: got beats=%0d issues=%0d expected 10 10", beats, iss); end
    endtask

    task automatic test_backpressure();
        logic [0:23] pat  = 24'b1001_1010_0111_0010_1100_1011;
        logic [W-1:0] held = '0;
        logic stalled = 1'b0;
        int beats  = 0;
        int issued = 0;
        issue_cmd(8'd0, 9'd8);
        for (int c = 0; c < 60 && beats < 8; c++) begin
            rd_ready = (c < 24) ? pat[c] : 1'b1;
            @(negedge clk);
            if (bram_enb) issued++;
            if (stalled) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== held) begin errors++; $display("FAIL bp_stall_hold cycle %0d: got valid=%b data=%h expected 1 %h", c, rd_valid, rd_data, held); end
            end
            stalled = 1'b0;
            if (rd_valid) begin
                if (rd_ready) begin
                    checks++; if (rd_data !== word_of(8'(beats))) begin errors++; $display("FAIL bp_data beat %0d: got %h expected %h", beats, rd_data, word_of(8'(beats))); end
                    checks++; if (rd_last !== (beats == 7)) begin errors++; $display("FAIL bp_last beat %0d: got %b expected %b", beats, rd_last, (beats == 7)); end
                    beats++;
                end else begin
                    stalled = 1'b1;
                    held    = rd_data;
                end
            end
            checks++; if (issued - beats > 2) begin errors++; $display("FAIL bp_outstanding cycle %0d: got %0d expected <=2", c, issued - beats); end
            @(posedge clk); #1;
        end
        checks++; if (beats != 8 || issued != 8) begin errors++; $display("FAIL bp_count: got beats=%0d issues=%0d expected 8 8", beats, issued); end
        rd_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_no_extra cycle %0d: got valid=%b busy=%b expected 0 0", c, rd_valid, busy); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rw_collision();
        logic [W-1:0] old_w = {16{8'h5A}};
        logic [W-1:0] new_w = {16{8'hA5}};
        int beats;
        host_write(8'h60, old_w);
        rd_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            issue_cmd(8'h60, 9'd1);
            if (pass == 0) begin
                host_wr_valid = 1'b1;
                host_wr_addr  = 8'h60;
                host_wr_data  = new_w;
                @(negedge clk);
                checks++; if (bram_enb !== 1'b1 || bram_addrb !== 8'h60 || bram_wea !== 1'b1) begin errors++; $display("FAIL rw_same_cycle: got enb=%b addrb=%h wea=%b expected 1 60 1", bram_enb, bram_addrb, bram_wea); end
                @(posedge clk); #1;
                host_wr_valid = 1'b0;
            end
            beats = 0;
            for (int c = 0; c < 10 && beats < 1; c++) begin
                @(negedge clk);
                if (rd_valid) begin
                    checks++; if (rd_data !== (pass == 0 ? old_w : new_w)) begin errors++; $display("FAIL rw_data pass %0d: got %h expected %h", pass, rd_data, (pass == 0 ? old_w : new_w)); end
                    checks++; if (rd_last !== 1'b1) begin errors++; $display("FAIL rw_last pass %0d: got %b expected 1", pass, rd_last); end
                    beats++;
                end
                @(posedge clk); #1;
            end
            checks++; if (beats != 1) begin errors++; $display("FAIL rw_count pass %0d: got %0d expected 1", pass, beats); end
        end
    endtask

    task automatic test_len0_and_busy();
        int got = 0;
        issue_cmd(8'd5, 9'd0);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_idle: got ready=%b busy=%b expected 1 0", cmd_ready, busy); end
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (rd_valid !== 1'b0 || bram_enb !== 1'b0) begin errors++; $display("FAIL len0_no_beat cycle %0d: got valid=%b enb=%b expected 0 0", c, rd_valid, bram_enb); end
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        issue_cmd(8'd0, 9'd4);
        cmd_valid = 1'b1;
        cmd_base  = 8'h64;
        cmd_len   = 9'd4;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (c < 3) begin
                checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL busy_cmd_ignored cycle %0d: got ready=%b busy=%b expected 0 1", c, cmd_ready, busy); end
            end
            if (rd_valid) begin
                checks++; if (rd_data !== word_of(8'(got))) begin errors++; $display("FAIL busy_data beat %0d: got %h expected %h", got, rd_data, word_of(8'(got))); end
                checks++; if (rd_last !== (got == 3)) begin errors++; $display("FAIL busy_last beat %0d: got %b expected %b", got, rd_last, (got == 3)); end
                got++;
            end
            @(posedge clk); #1;
            if (c == 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        checks++; if (got != 4) begin errors++; $display("FAIL busy_count: got %0d expected 4", got); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL busy_no_second_burst cycle %0d: got valid=%b busy=%b expected 0 0", c, rd_valid, busy); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        rd_ready = 1'b1;
        issue_cmd(8'd0, 9'd16);
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (rd_valid) got++;
            @(posedge clk); #1;
        end
        checks++; if (got != 3 || rd_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got beats=%0d valid=%b expected 3 1", got, rd_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_last !== 1'b0) begin errors++; $display("FAIL midrst_flush: got valid=%b busy=%b last=%b expected 0 0 0", rd_valid, busy, rd_last); end
        checks++; if (cmd_ready !== 1'b1 || bram_enb !== 1'b0) begin errors++; $display("FAIL midrst_idle: got ready=%b enb=%b expected 1 0", cmd_ready, bram_enb); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        got = 0;
        issue_cmd(8'd8, 9'd4);
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                checks++; if (rd_data !== word_of(8'(8 + got))) begin errors++; $display("FAIL midrst_data beat %0d: got %h expected %h", got, rd_data, word_of(8'(8 + got))); end
                checks++; if (rd_last !== (got == 3)) begin errors++; $display("FAIL midrst_last beat %0d: got %b expected %b", got, rd_last, (got == 3)); end
                got++;
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL midrst_count: got %0d expected 4", got); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_end_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_arbiter();
        test_wrap();
        test_backpressure();
        test_rw_collision();
        test_len0_and_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
